// File: rtl/bf16_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined bf16 multiplier among N requesters.
// Each issued op carries its requester ID down a tag pipe matched to the multiplier latency.
module bf16_mul_arbiter #(
   parameter int N   = 4,
   parameter int LAT = 3,
   parameter int IDW = $clog2(N),
   parameter int CW  = $clog2(LAT + 2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   input  logic [16*N-1:0]   req_a,
   input  logic [16*N-1:0]   req_b,
   output logic [N-1:0]      req_ready,
   output logic [N-1:0]      rsp_valid,
   output logic [15:0]       rsp_result,
   output logic [IDW-1:0]    rsp_id,
   output logic [15:0]       mul_a,
   output logic [15:0]       mul_b,
   output logic              mul_in_valid,
   input  logic [15:0]       mul_result,
   input  logic              mul_out_valid,
   input  logic              pause,
   output logic              idle,
   output logic [CW-1:0]     inflight,
   output logic              err
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] grant_id;
   logic           grant_found;
   logic [15:0]    sel_a;
   logic [15:0]    sel_b;
   logic           handshake;
   logic [IDW-1:0] issue_id;
   logic [LAT-1:0] tag_v;
   logic [IDW-1:0] tag_id [LAT];
   logic           exit_v;
   logic [IDW-1:0] exit_id;
   logic           rsp_fire;

   // Scan ptr, ptr+1, ... wrapping at N; the first valid lane wins.
   always_comb begin
      logic [IDW:0] lane;
      lane        = '0;
      grant_found = 1'b0;
      grant_id    = '0;
      sel_a       = '0;
      sel_b       = '0;
      for (int k = 0; k < N; k++) begin
         lane = {1'b0, ptr} + (IDW+1)'(k);
         if (lane >= (IDW+1)'(N)) begin
            lane = lane - (IDW+1)'(N);
         end
         if (!grant_found && req_valid[lane[IDW-1:0]]) begin
            grant_found = 1'b1;
            grant_id    = lane[IDW-1:0];
            sel_a       = req_a[{lane[IDW-1:0], 4'b0000} +: 16];
            sel_b       = req_b[{lane[IDW-1:0], 4'b0000} +: 16];
         end
      end
   end

   assign handshake = !pause && grant_found;

   always_comb begin
      req_ready = '0;
      if (handshake) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr          <= '0;
         mul_a        <= '0;
         mul_b        <= '0;
         mul_in_valid <= 1'b0;
         issue_id     <= '0;
      end else begin
         mul_in_valid <= handshake;
         if (handshake) begin
            mul_a    <= sel_a;
            mul_b    <= sel_b;
            issue_id <= grant_id;
            ptr      <= (grant_id == IDW'(N-1)) ? '0 : grant_id + IDW'(1);
         end
      end
   end

   // Stage 0 samples the issue strobe, so the last stage lines up with mul_out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
         for (int s = 0; s < LAT; s++) begin
            tag_id[s] <= '0;
         end
      end else begin
         tag_v[0]  <= mul_in_valid;
         tag_id[0] <= issue_id;
         for (int s = 1; s < LAT; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   assign exit_v     = tag_v[LAT-1];
   assign exit_id    = tag_id[LAT-1];
   assign rsp_fire   = exit_v && mul_out_valid;
   assign rsp_id     = exit_id;
   assign rsp_result = mul_result;

   always_comb begin
      rsp_valid = '0;
      if (rsp_fire) begin
         rsp_valid[exit_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
         err      <= 1'b0;
      end else begin
         if (handshake && !rsp_fire && inflight != CW'(LAT+1)) begin
            inflight <= inflight + CW'(1);
         end else if (!handshake && rsp_fire && inflight != '0) begin
            inflight <= inflight - CW'(1);
         end
         if (exit_v != mul_out_valid) begin
            err <= 1'b1;
         end
      end
   end

   assign idle = (inflight == '0);

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Self-checking bench for bf16_mul_arbiter: a latency-LAT multiplier model plus a
// queue-based reference of grants, responses, in-flight count and error flag.
module tb_bf16_mul_arbiter;

   localparam int N   = 4;
   localparam int LAT = 3;
   localparam int IDW = $clog2(N);
   localparam int CW  = $clog2(LAT + 2);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [16*N-1:0] req_a = '0;
   logic [16*N-1:0] req_b = '0;
   logic            pause = 1'b0;
   logic            force_ov = 1'b0;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [15:0]     rsp_result, mul_a, mul_b, mul_result;
   logic [IDW-1:0]  rsp_id;
   logic            mul_in_valid, mul_out_valid, idle, err;
   logic [CW-1:0]   inflight;

   int total = 0;
   int bad   = 0;

   bf16_mul_arbiter #(.N(N), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_id(rsp_id),
      .mul_a(mul_a), .mul_b(mul_b), .mul_in_valid(mul_in_valid), .mul_result(mul_result),
      .mul_out_valid(mul_out_valid), .pause(pause), .idle(idle), .inflight(inflight), .err(err)
   );

   always #5 clk = ~clk;

   // Truncating bf16 multiply for normal operands whose product stays in range.
   function automatic logic [15:0] bf16_mul_ref(input logic [15:0] a, input logic [15:0] b);
      int e;
      int p;
      logic [6:0] m;
      e = int'(a[14:7]) + int'(b[14:7]) - 127;
      p = (128 + int'(a[6:0])) * (128 + int'(b[6:0]));
      if (p >= 32768) begin
         m = 7'((p >> 8) & 127);
         e = e + 1;
      end else begin
         m = 7'((p >> 7) & 127);
      end
      return {a[15] ^ b[15], 8'(e), m};
   endfunction

   function automatic logic [15:0] rand_bf16();
      logic [15:0] v;
      v[15]   = 1'($urandom % 2);
      v[14:7] = 8'(110 + ($urandom % 35));
      v[6:0]  = 7'($urandom % 128);
      return v;
   endfunction

   logic [15:0] mp_res [LAT];
   logic        mp_v   [LAT];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            mp_v[i]   <= 1'b0;
            mp_res[i] <= 16'h0;
         end
      end else begin
         mp_v[0]   <= mul_in_valid;
         mp_res[0] <= bf16_mul_ref(mul_a, mul_b);
         for (int i = 1; i < LAT; i++) begin
            mp_v[i]   <= mp_v[i-1];
            mp_res[i] <= mp_res[i-1];
         end
      end
   end

   assign mul_out_valid = mp_v[LAT-1] | force_ov;
   assign mul_result    = mp_res[LAT-1];

   typedef struct {
      int          due;
      int          id;
      logic [15:0] prod;
   } rsp_t;

   rsp_t        rsp_q[$];
   int          cyc;
   int          m_ptr;
   int          m_inflight;
   bit          m_err;
   bit          m_miv;
   logic [15:0] m_mul_a;
   int          exp_grant;
   logic [N-1:0] exp_ready;
   logic [N-1:0] exp_rsp;
   logic [15:0] exp_res;
   int          exp_id;

   task automatic model_clear();
      rsp_q.delete();
      cyc        = 0;
      m_ptr      = 0;
      m_inflight = 0;
      m_err      = 0;
      m_miv      = 0;
      m_mul_a    = 16'h0;
   endtask

   task automatic model_eval();
      exp_grant = -1;
      exp_ready = '0;
      if (!pause) begin
         for (int k = 0; k < N; k++) begin
            if (exp_grant < 0 && req_valid[(m_ptr + k) % N]) exp_grant = (m_ptr + k) % N;
         end
      end
      if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
      exp_rsp = '0;
      exp_res = 16'h0;
      exp_id  = 0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         exp_rsp[rsp_q[0].id] = 1'b1;
         exp_res = rsp_q[0].prod;
         exp_id  = rsp_q[0].id;
      end
   endtask

   task automatic model_commit();
      bit hs;
      bit rs;
      rsp_t r;
      hs = (exp_grant >= 0);
      rs = (exp_rsp != '0);
      if (hs) begin
         r.due  = cyc + 1 + LAT;
         r.id   = exp_grant;
         r.prod = bf16_mul_ref(req_a[16*exp_grant +: 16], req_b[16*exp_grant +: 16]);
         rsp_q.push_back(r);
         m_mul_a = req_a[16*exp_grant +: 16];
         m_ptr   = (exp_grant + 1) % N;
      end
      if (rs) void'(rsp_q.pop_front());
      m_inflight = m_inflight + int'(hs) - int'(rs);
      if (force_ov && !rs) m_err = 1;
      m_miv = hs;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      pause     = 1'b0;
      force_ov  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", req_ready); end
      total++; if (rsp_valid !== '0) begin bad++; $display("[TB] FAIL reset_rsp got=%b exp=0", rsp_valid); end
      total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL reset_idle got=%b exp=1", idle); end
      total++; if (inflight !== '0) begin bad++; $display("[TB] FAIL reset_inflight got=%0d exp=0", inflight); end
      total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
      total++; if (mul_in_valid !== 1'b0 || mul_a !== 16'h0 || mul_b !== 16'h0) begin
         bad++; $display("[TB] FAIL reset_mul got=%b/%h/%h exp=0/0000/0000", mul_in_valid, mul_a, mul_b);
      end
      req_valid = 4'b1111;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("[TB] FAIL reset_ptr got=%b exp=0001", req_ready); end
      req_valid = '0;
   endtask

   task automatic test_single_op();
      do_reset();
      req_valid = 4'b0001;
      req_a[15:0] = 16'h3F80;
      req_b[15:0] = 16'h4000;
      for (int c = 0; c < 7; c++) begin
         #1;
         model_eval();
         total++; if (req_ready !== exp_ready) begin bad++; $display("[TB] FAIL single_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
         total++; if (mul_in_valid !== (c == 1)) begin bad++; $display("[TB] FAIL single_miv c=%0d got=%b exp=%b", c, mul_in_valid, c == 1); end
         total++; if (rsp_valid !== ((c == 4) ? 4'b0001 : 4'b0000)) begin bad++; $display("[TB] FAIL single_rsp c=%0d got=%b", c, rsp_valid); end
         total++; if (idle !== !(c >= 1 && c <= 4)) begin bad++; $display("[TB] FAIL single_idle c=%0d got=%b", c, idle); end
         if (c == 1) begin
            total++; if (mul_a !== 16'h3F80 || mul_b !== 16'h4000) begin bad++; $display("[TB] FAIL single_mulab got=%h/%h exp=3f80/4000", mul_a, mul_b); end
         end
         if (c == 4) begin
            total++; if (rsp_result !== 16'h4000 || rsp_id !== '0) begin bad++; $display("[TB] FAIL single_result got=%h id=%0d exp=4000 id=0", rsp_result, rsp_id); end
         end
         model_commit();
         req_valid = '0;
      end
   endtask

   task automatic test_round_robin();
      logic [15:0] prods [4];
      int rcount;
      int peak;
      prods[0] = 16'h4000; prods[1] = 16'h4080; prods[2] = 16'h40C0; prods[3] = 16'h4100;
      rcount = 0;
      peak   = 0;
      do_reset();
      req_a = {16'h4080, 16'h4040, 16'h4000, 16'h3F80};
      req_b = {4{16'h4000}};
      for (int c = 0; c < 14; c++) begin
         req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         #1;
         model_eval();
         if (int'(inflight) > peak) peak = int'(inflight);
         total++; if (req_ready !== exp_ready || (c < 8 && req_ready !== 4'(1 << (c % 4)))) begin
            bad++; $display("[TB] FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_ready);
         end
         total++; if (rsp_valid !== exp_rsp) begin bad++; $display("[TB] FAIL rr_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
         if (exp_rsp != '0) begin
            total++; if (rsp_id !== IDW'(rcount % 4) || rsp_result !== prods[rcount % 4]) begin
               bad++; $display("[TB] FAIL rr_result c=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_result, rcount % 4, prods[rcount % 4]);
            end
            rcount++;
         end
         model_commit();
      end
      total++; if (peak != LAT + 1) begin bad++; $display("[TB] FAIL rr_peak got=%0d exp=%0d", peak, LAT + 1); end
      total++; if (rcount != 8) begin bad++; $display("[TB] FAIL rr_count got=%0d exp=8", rcount); end
   endtask

   task automatic test_ptr_skip();
      do_reset();
      req_valid = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         #1;
         model_eval();
         total++; if (req_ready !== exp_ready || req_ready !== ((c % 2 == 0) ? 4'b0010 : 4'b1000)) begin
            bad++; $display("[TB] FAIL skip_grant c=%0d got=%b exp=%b", c, req_ready, exp_ready);
         end
         model_commit();
      end
      req_valid = '0;
   endtask

   task automatic test_pause();
      int rcount;
      rcount = 0;
      do_reset();
      req_a = {4{rand_bf16()}};
      req_b = {4{rand_bf16()}};
      req_valid = 4'b1111;
      for (int c = 0; c < 12; c++) begin
         pause = (c >= 5 && c <= 10);
         #1;
         model_eval();
         total++; if (req_ready !== exp_ready) begin bad++; $display("[TB] FAIL pause_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
         total++; if (rsp_valid !== exp_rsp) begin bad++; $display("[TB] FAIL pause_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
         if (exp_rsp != '0) rcount++;
         if (c == 5) begin
            total++; if (inflight !== CW'(4)) begin bad++; $display("[TB] FAIL pause_full got=%0d exp=4", inflight); end
         end
         if (c == 10) begin
            total++; if (inflight !== '0 || idle !== 1'b1) begin bad++; $display("[TB] FAIL pause_drain got=%0d/%b exp=0/1", inflight, idle); end
         end
         if (c == 11) begin
            total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL pause_resume got=%b exp=0010", req_ready); end
         end
         model_commit();
      end
      req_valid = '0;
      pause = 1'b0;
      total++; if (rcount != 5) begin bad++; $display("[TB] FAIL pause_count got=%0d exp=5", rcount); end
   endtask

   task automatic test_reset_mid();
      int seen;
      do_reset();
      req_valid = 4'b0111;
      for (int c = 0; c < 3; c++) begin
         #1;
         model_eval();
         model_commit();
      end
      do_reset();
      for (int c = 0; c < 6; c++) begin
         #1;
         total++; if (rsp_valid !== '0 || inflight !== '0 || err !== 1'b0) begin
            bad++; $display("[TB] FAIL rstmid_quiet c=%0d got=%b/%0d/%b exp=0/0/0", c, rsp_valid, inflight, err);
         end
         @(posedge clk);
         @(negedge clk);
      end
      model_clear();
      seen = -1;
      req_valid = 4'b0100;
      req_a[47:32] = 16'h4040;
      req_b[47:32] = 16'h4040;
      for (int c = 0; c < 8; c++) begin
         #1;
         model_eval();
         total++; if (rsp_valid !== exp_rsp) begin bad++; $display("[TB] FAIL rstmid_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
         if (rsp_valid != '0 && seen < 0) seen = c;
         model_commit();
         req_valid = '0;
      end
      total++; if (seen != LAT + 1) begin bad++; $display("[TB] FAIL rstmid_latency got=%0d exp=%0d", seen, LAT + 1); end
   endtask

   task automatic test_protocol_err();
      do_reset();
      force_ov = 1'b1;
      #1;
      model_eval();
      total++; if (rsp_valid !== '0) begin bad++; $display("[TB] FAIL perr_rsp got=%b exp=0", rsp_valid); end
      model_commit();
      force_ov = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         total++; if (err !== 1'(m_err) || err !== 1'b1) begin bad++; $display("[TB] FAIL perr_sticky c=%0d got=%b exp=1", c, err); end
         model_eval();
         model_commit();
      end
      do_reset();
      #1;
      total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL perr_clear got=%b exp=0", err); end
   endtask

   task automatic test_random();
      int g;
      do_reset();
      for (int c = 0; c < 400 + LAT + 3; c++) begin
         for (int i = 0; i < N; i++) begin
            if (c >= 400) begin
               req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
               if ($urandom % 3 == 0) begin
                  req_valid[i] = 1'b1;
                  req_a[16*i +: 16] = rand_bf16();
                  req_b[16*i +: 16] = rand_bf16();
               end
            end else if ($urandom % 16 == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         pause = (c < 400) && ($urandom % 8 == 0);
         #1;
         model_eval();
         total++; if (req_ready !== exp_ready) begin bad++; $display("[TB] FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
         total++; if (rsp_valid !== exp_rsp) begin bad++; $display("[TB] FAIL rand_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
         if (exp_rsp != '0) begin
            total++; if (rsp_id !== IDW'(exp_id) || rsp_result !== exp_res) begin
               bad++; $display("[TB] FAIL rand_result c=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_result, exp_id, exp_res);
            end
         end
         total++; if (int'(inflight) != m_inflight || idle !== (m_inflight == 0)) begin
            bad++; $display("[TB] FAIL rand_inflight c=%0d got=%0d/%b exp=%0d", c, inflight, idle, m_inflight);
         end
         total++; if (mul_in_valid !== m_miv || (m_miv && mul_a !== m_mul_a)) begin
            bad++; $display("[TB] FAIL rand_issue c=%0d got=%b/%h exp=%b/%h", c, mul_in_valid, mul_a, m_miv, m_mul_a);
         end
         total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rand_err c=%0d got=%b exp=0", c, err); end
         g = exp_grant;
         model_commit();
         if (g >= 0) req_valid[g] = 1'b0;
      end
      total++; if (idle !== 1'b1) begin bad++; $display("[TB] FAIL rand_final_idle got=%b exp=1", idle); end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_ptr_skip();
      test_pause();
      test_reset_mid();
      test_protocol_err();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bf16_mul_arbiter.md
Name: bf16_mul_arbiter

Overview:
Round-robin arbiter that shares one pipelined bf16_multiplier among N requesters in the MAC array.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle.
- Tags each issued pair with its requester ID, carries the tag alongside the multiplier pipeline, and routes each result back to the owning requester.
- Adds pause, idle/in-flight status and a sticky protocol-error flag.

Parameters:
N, 4, number of requesters (2..16)
LAT, 3, multiplier latency in cycles from mul_in_valid to mul_out_valid (fixed, no stall)
IDW, $clog2(N), requester ID width (derived)
CW, $clog2(LAT+2), in-flight counter width (derived)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset; integrator drives multiplier rst_n = ~rst
req_valid  input  N  per-requester operand valid
req_a  input  16*N  bf16 operand A; requester i uses bits [16i+15:16i]
req_b  input  16*N  bf16 operand B; same packing as req_a
req_ready  output  N  one-hot accept; combinational from req_valid, ptr and pause
rsp_valid  output  N  one-hot result strobe, one cycle, cannot be back-pressured
rsp_result  output  16  bf16 product, valid when any rsp_valid bit is set
rsp_id  output  IDW  requester ID of current result
mul_a  output  16  registered operand A to multiplier
mul_b  output  16  registered operand B to multiplier
mul_in_valid  output  1  registered issue strobe to multiplier
mul_result  input  16  multiplier result
mul_out_valid  input  1  multiplier result valid
pause  input  1  when high, no new grants; in-flight work drains
idle  output  1  high when in-flight count is 0
inflight  output  CW  number of accepted, not yet returned operations
err  output  1  sticky protocol error; cleared only by rst

Behaviour:
- Reset values (rst sampled high at posedge): ptr=0, mul_a=0, mul_b=0, mul_in_valid=0, tag pipe all invalid, inflight=0, err=0. Outputs then read req_ready=0 and rsp_valid=0, so idle=1. Reset mid-operation discards all in-flight work; no response is produced for it.
- Arbitration: if pause=0 and req_valid!=0, grant g = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod N. req_ready = onehot(g), else 0.
  - Handshake completes when req_valid[g] & req_ready[g].
  - Requesters must hold operands stable while valid and unaccepted.
- Issue (on handshake at edge T):
  - mul_a/mul_b <= operands of g; mul_in_valid <= 1; ptr <= (g+1) mod N.
  - Without a handshake, mul_in_valid <= 0; mul_a/mul_b hold; ptr holds.
- Throughput: one accept per cycle; back-to-back grants allowed, including the same requester when it is the only one valid.
- Tag pipe: LAT-stage shift register of {valid, id}. Stage 0 loads {mul_in_valid, id of issued op} each cycle; the tag exits aligned with the expected mul_out_valid.
- Response (combinational on tag exit):
  - If tag_valid & mul_out_valid: rsp_valid = onehot(tag_id), rsp_id = tag_id, rsp_result = mul_result.
  - Otherwise rsp_valid = 0. rsp_result and rsp_id are don't-care but must not be X after reset; drive mul_result and tag_id.
- Latency: handshake in cycle T gives mul_in_valid high in T+1 and rsp_valid in T+1+LAT (T+4 for LAT=3).
- Protocol check: err <= 1 on any cycle where tag_valid != mul_out_valid. On a spurious mul_out_valid (no tag), rsp_valid stays 0.
- inflight arithmetic:
  - +1 on handshake, -1 on rsp (tag_valid & mul_out_valid); simultaneous handshake and rsp leaves it unchanged.
  - Maximum value is LAT+1; it never wraps.
  - idle = (inflight==0).
- Pause: takes effect combinationally, so no handshake occurs in any cycle with pause=1. ptr holds while paused. Already-issued ops complete normally.
- Requester drops valid before grant: allowed, nothing issued. A requester changing operands under valid is undefined.

Test Plan:
- Single op: after reset, req_valid=0001, req_a=3F80, req_b=4000 accepted at T -> mul_in_valid at T+1, rsp_valid=0001, rsp_id=0, rsp_result=4000 at T+4; idle 1 -> 0 -> 1.
- Round-robin fairness: all four req_valid held high for 8 cycles (lane i operands i+1.0 * 2.0) -> grant order 0,1,2,3,0,1,2,3; responses arrive 4 cycles later in the same order with correct products; peak inflight=4.
- Pointer skip: req_valid=1010 held, ptr=0 after reset -> grants 1,3,1,3; lanes 0/2 never get req_ready.
- Pause: 4 ops in flight, then pause=1 for 6 cycles with all requests valid -> req_ready=0 throughout; 4 responses still delivered; inflight reaches 0 and idle=1; grants resume at the held ptr after pause drops.
- Reset mid-operation: rst high for 1 cycle with 3 ops in flight -> no rsp_valid afterwards; inflight=0, err=0; the next op completes with LAT+1 latency.
- Protocol error: force mul_out_valid=1 with empty tag pipe -> rsp_valid=0 and err=1 the next cycle; err stays 1 until rst.
